// File: rtl/bus_timer_pkg.sv
// Shared register map and CTRL layout for the bus timer responder.
package bus_timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    localparam int EN_BIT    = 0;
    localparam int AR_BIT    = 1;
    localparam int IE_BIT    = 2;
    localparam int PRESC_LSB = 8;
    localparam int PRESC_MSB = 15;

    typedef struct packed {
        logic [7:0] presc;
        logic       ie;
        logic       ar;
        logic       en;
    } ctrl_t;

    // Unimplemented CTRL bits read back as zero.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] w;
        w = 32'd0;
        w[EN_BIT] = c.en;
        w[AR_BIT] = c.ar;
        w[IE_BIT] = c.ie;
        w[PRESC_MSB:PRESC_LSB] = c.presc;
        return w;
    endfunction

    function automatic ctrl_t word_to_ctrl(input logic [31:0] w);
        ctrl_t c;
        c.en    = w[EN_BIT];
        c.ar    = w[AR_BIT];
        c.ie    = w[IE_BIT];
        c.presc = w[PRESC_MSB:PRESC_LSB];
        return c;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler: ticks when the running count equals presc, then wraps to 0.
module timer_prescaler (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       en,
    input  logic [7:0] presc,
    input  logic       clr,
    output logic       tick
);

    logic [7:0] pc_q;
    logic [7:0] pc_d;

    always_comb begin
        tick = en && (pc_q == presc);
        pc_d = pc_q + 8'd1;
        // Disabled, a new divide ratio, or a tick all restart the count.
        if (!en || clr || tick) begin
            pc_d = 8'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pc_q <= 8'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/bus_timer_responder.sv
// Memory-mapped down-counting timer on the CPU external data bus.
module bus_timer_responder
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0800,
    parameter logic [31:0] RESET_LOAD = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WE,
    output logic [31:0] Data_BUS_READ,
    output logic        IRQ
);

    // Access semantics: every cycle with CS high and an address in the window is
    // accepted at the next rising edge (no stall); reads return data one cycle later.
    logic       sel;
    logic [1:0] off;
    logic       wr_en;
    logic       rd_en;
    logic       wr_ctrl;
    logic       wr_load;
    logic       wr_count;
    logic       wr_status;
    logic       tick;
    logic       expire;
    logic       unused_addr_bits;

    ctrl_t       ctrl_q, ctrl_d;
    logic [31:0] load_q, load_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic [31:0] rdata_q, rdata_d;

    assign unused_addr_bits = ^ADDR[1:0];

    always_comb begin
        sel       = CS && (ADDR[31:4] == BASE_ADDR[31:4]);
        off       = ADDR[3:2];
        wr_en     = sel && WE;
        rd_en     = sel && !WE;
        wr_ctrl   = wr_en && (off == OFF_CTRL);
        wr_load   = wr_en && (off == OFF_LOAD);
        wr_count  = wr_en && (off == OFF_COUNT);
        wr_status = wr_en && (off == OFF_STATUS);
        expire    = tick && (count_q == 32'd0);
    end

    timer_prescaler u_prescaler (
        .CLK   (CLK),
        .Reset (Reset),
        .en    (ctrl_q.en),
        .presc (ctrl_q.presc),
        .clr   (wr_ctrl),
        .tick  (tick)
    );

    // Later assignments override earlier ones: CPU writes beat timer events,
    // except that expiry beats a W1C clear of EXP.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        exp_d   = exp_q;

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else if (ctrl_q.ar) begin
                count_d = load_q;
            end else begin
                ctrl_d.en = 1'b0;
            end
        end

        if (wr_ctrl) begin
            ctrl_d = word_to_ctrl(Data_BUS_WRITE);
        end
        if (wr_load) begin
            load_d = Data_BUS_WRITE;
        end
        if (wr_count) begin
            count_d = Data_BUS_WRITE;
        end
        if (wr_status && Data_BUS_WRITE[0]) begin
            exp_d = 1'b0;
        end
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            case (off)
                OFF_CTRL:   rdata_d = ctrl_to_word(ctrl_q);
                OFF_LOAD:   rdata_d = load_q;
                OFF_COUNT:  rdata_d = count_q;
                default:    rdata_d = {31'd0, exp_q};
            endcase
        end else if (!sel) begin
            rdata_d = 32'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            ctrl_q  <= '0;
            load_q  <= RESET_LOAD;
            count_q <= 32'd0;
            exp_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            exp_q   <= exp_d;
            rdata_q <= rdata_d;
        end
    end

    assign Data_BUS_READ = rdata_q;
    assign IRQ           = exp_q && ctrl_q.ie;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Directed bench for bus_timer_responder with hand-computed expectations.
module tb_bus_timer_responder;

    localparam logic [31:0] BASE = 32'h0000_0800;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic        CS;
    logic        WE;
    logic [31:0] Data_BUS_READ;
    logic        IRQ;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    bus_timer_responder #(
        .BASE_ADDR  (BASE),
        .RESET_LOAD (32'hFFFF_FFFF)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .CS             (CS),
        .WE             (WE),
        .Data_BUS_READ  (Data_BUS_READ),
        .IRQ            (IRQ)
    );

    // Clock / watchdog
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, return 1ns after the capturing edge.
    task automatic bus(input logic cs, input logic we, input logic [31:0] addr, input logic [31:0] data);
        @(negedge CLK);
        CS = cs;
        WE = we;
        ADDR = addr;
        Data_BUS_WRITE = data;
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] data);
        bus(1'b1, 1'b1, BASE + {28'd0, off, 2'b00}, data);
    endtask

    task automatic rd(input string tag, input logic [1:0] off, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus(1'b1, 1'b0, BASE + {28'd0, off, 2'b00}, 32'd0);
        check_eq(tag, Data_BUS_READ, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) bus(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        CS = 1'b0;
        WE = 1'b0;
        ADDR = 32'd0;
        Data_BUS_WRITE = 32'd0;
        Reset = 1'b1;
        idle(2);
        Reset = 1'b0;

        // Reset values
        check_eq("rst_irq", {31'd0, IRQ}, 32'd0);
        check_eq("rst_rdata", Data_BUS_READ, 32'd0);
        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_load", 2'd1, 32'hFFFF_FFFF);
        rd("rst_count", 2'd2, 32'h0);
        rd("rst_status", 2'd3, 32'h0);

        // Auto-reload, PRESC=0: ticks every cycle after the CTRL write
        wr(2'd1, 32'd3);
        wr(2'd2, 32'd3);
        wr(2'd0, 32'h7);
        rd("ar_cnt3", 2'd2, 32'd3);
        rd("ar_cnt2", 2'd2, 32'd2);
        rd("ar_cnt1", 2'd2, 32'd1);
        rd("ar_cnt0", 2'd2, 32'd0);
        check_eq("ar_irq", {31'd0, IRQ}, 32'd1);
        rd("ar_exp", 2'd3, 32'd1);
        rd("ar_reload", 2'd2, 32'd2);
        wr(2'd0, 32'h0);
        wr(2'd3, 32'h1);
        rd("ar_w1c", 2'd3, 32'd0);
        check_eq("ar_irq_clr", {31'd0, IRQ}, 32'd0);

        // One-shot with PRESC=4: a tick every 5 cycles, expiry on the third
        wr(2'd2, 32'd2);
        wr(2'd0, 32'h0000_0401);
        for (int k = 1; k <= 17; k++) begin
            rd($sformatf("os_cnt_k%0d", k), 2'd2, (k <= 5) ? 32'd2 : ((k <= 10) ? 32'd1 : 32'd0));
        end
        rd("os_exp", 2'd3, 32'd1);
        rd("os_en_clr", 2'd0, 32'h0000_0400);
        check_eq("os_irq_masked", {31'd0, IRQ}, 32'd0);
        wr(2'd3, 32'h1);
        rd("os_w1c", 2'd3, 32'd0);

        // Out-of-window and deselected accesses
        rd("win_load", 2'd1, 32'd3);
        wr(2'd0, 32'h0000_0400);
        check_eq("wr_hold", Data_BUS_READ, 32'd3);
        bus(1'b1, 1'b1, BASE + 32'h14, 32'hDEAD);
        check_eq("oow_wr", Data_BUS_READ, 32'd0);
        rd("win_load2", 2'd1, 32'd3);
        bus(1'b1, 1'b0, BASE + 32'h10, 32'd0);
        check_eq("oow_rd", Data_BUS_READ, 32'd0);
        bus(1'b0, 1'b1, BASE + 32'h4, 32'hBEEF);
        check_eq("nocs_wr", Data_BUS_READ, 32'd0);
        rd("nocs_load", 2'd1, 32'd3);
        rd("nocs_ctrl", 2'd0, 32'h0000_0400);
        rd("nocs_count", 2'd2, 32'd0);

        // COUNT write coincident with a tick
        wr(2'd2, 32'h20);
        wr(2'd0, 32'h1);
        wr(2'd2, 32'h10);
        rd("cw_win", 2'd2, 32'h10);
        wr(2'd0, 32'h0);
        rd("cw_after", 2'd2, 32'h0E);

        // W1C coincident with expiry
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        wr(2'd3, 32'h1);
        rd("w1c_exp_wins", 2'd3, 32'd1);
        rd("w1c_en_clr", 2'd0, 32'h0);
        wr(2'd3, 32'h1);
        rd("w1c_clear", 2'd3, 32'd0);

        // CTRL write coincident with one-shot EN clear
        wr(2'd0, 32'h1);
        wr(2'd0, 32'h5);
        rd("ctrl_win", 2'd0, 32'h5);
        check_eq("ctrl_irq", {31'd0, IRQ}, 32'd1);
        rd("ctrl_os_clr", 2'd0, 32'h4);

        // Reset while counting with EXP set
        wr(2'd2, 32'h55);
        wr(2'd0, 32'h7);
        rd("mid_count", 2'd2, 32'h55);
        check_eq("mid_irq", {31'd0, IRQ}, 32'd1);
        Reset = 1'b1;
        idle(1);
        Reset = 1'b0;
        check_eq("mrst_irq", {31'd0, IRQ}, 32'd0);
        check_eq("mrst_rdata", Data_BUS_READ, 32'd0);
        rd("mrst_ctrl", 2'd0, 32'h0);
        rd("mrst_load", 2'd1, 32'hFFFF_FFFF);
        rd("mrst_count", 2'd2, 32'h0);
        rd("mrst_status", 2'd3, 32'h0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
